// File: rtl/bg_block_mem_ctrl_pkg.sv
// Shared types and constants for the BG block cache memory controller.
// Step codes, FSM states and the latched request record.
package gpu_bg_pkg;

  localparam int BLOCK_ADR_W = 15;
  localparam int BLOCK_W     = 256;
  localparam int MASK_W      = 16;

  localparam logic [1:0] BG_NONE  = 2'b00;
  localparam logic [1:0] BG_FIRST = 2'b01;
  localparam logic [1:0] BG_NEXT  = 2'b10;
  localparam logic [1:0] BG_FLUSH = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    SAVE_CMD,
    LOAD_CMD,
    LOAD_WAIT,
    IMPORT,
    DONE
  } bg_state_t;

  // Actions are resolved at latch time, so code/noblend live on as do_*.
  typedef struct packed {
    logic                   do_save;
    logic                   do_load;
    logic [BLOCK_ADR_W-1:0] load_adr;
    logic [BLOCK_ADR_W-1:0] save_adr;
    logic [BLOCK_W-1:0]     block;
    logic [MASK_W-1:0]      mask;
  } bg_req_t;

  function automatic bg_state_t first_state(input bg_req_t r);
    bg_state_t s;
    s = IDLE;
    if (r.do_save)
      s = SAVE_CMD;
    else if (r.do_load)
      s = LOAD_CMD;
    return s;
  endfunction

endpackage

// File: rtl/bg_block_mem_ctrl_if.sv
// Single-beat VRAM command/read-data bus of the BG block controller.
// Master issues commands; slave is the VRAM/DDR arbiter.
interface bg_block_mem_ctrl_if
  import gpu_bg_pkg::*;
  ();

  logic                   cmd_valid;
  logic                   cmd_ready;
  logic                   write;
  logic [BLOCK_ADR_W-1:0] adr;
  logic [BLOCK_W-1:0]     wdata;
  logic [MASK_W-1:0]      wmask;
  logic                   rvalid;
  logic [BLOCK_W-1:0]     rdata;

  modport master (
    output cmd_valid,
    output write,
    output adr,
    output wdata,
    output wmask,
    input  cmd_ready,
    input  rvalid,
    input  rdata
  );

  modport slave (
    input  cmd_valid,
    input  write,
    input  adr,
    input  wdata,
    input  wmask,
    output cmd_ready,
    output rvalid,
    output rdata
  );

endinterface

// File: rtl/bg_block_mem_ctrl_slot.sv
// Request front end: step-code edge detect, action derivation,
// one-deep pending slot and sticky overrun flag.
module bg_req_slot
  import gpu_bg_pkg::*;
#(
  parameter bit SKIP_EMPTY_SAVE = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             code,
  input  logic                   noblend,
  input  logic [BLOCK_ADR_W-1:0] load_adr,
  input  logic [BLOCK_ADR_W-1:0] save_adr,
  input  logic [BLOCK_W-1:0]     block,
  input  logic [MASK_W-1:0]      mask,
  input  logic                   direct,
  input  logic                   take,
  output logic                   evt,
  output bg_req_t                req,
  output logic                   pend_vld,
  output bg_req_t                pend,
  output logic                   err_overrun
);

  logic [1:0] prev;
  logic       empty;
  logic       store;

  // Gated by reset so busy reads 0 while reset is held.
  assign evt = rst_n & (code != BG_NONE) & (code != prev);
  assign empty = SKIP_EMPTY_SAVE & (mask == '0);
  assign store = evt & ~direct;

  always_comb begin
    req          = '0;
    req.load_adr = load_adr;
    req.save_adr = save_adr;
    req.block    = block;
    req.mask     = mask;
    unique case (code)
      BG_FIRST: begin
        req.do_save = 1'b0;
        req.do_load = ~noblend;
      end
      BG_NEXT: begin
        req.do_save = ~empty;
        req.do_load = ~noblend;
      end
      BG_FLUSH: begin
        req.do_save = ~empty;
        req.do_load = 1'b0;
      end
      default: begin
        req.do_save = 1'b0;
        req.do_load = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev        <= BG_NONE;
      pend_vld    <= 1'b0;
      pend        <= '0;
      err_overrun <= 1'b0;
    end else begin
      prev <= code;
      if (store) begin
        if (pend_vld && !take) begin
          err_overrun <= 1'b1;
        end else begin
          pend     <= req;
          pend_vld <= 1'b1;
        end
      end else if (take) begin
        pend_vld <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/bg_block_mem_ctrl.sv
// BG block save/load controller: turns backend step codes into
// single-beat 256-bit VRAM writes/reads and returns loaded blocks.
module bg_block_mem_ctrl
  import gpu_bg_pkg::*;
#(
  parameter bit SKIP_EMPTY_SAVE = 1'b1
) (
  input  logic                   clk,
  input  logic                   i_nrst,
  input  logic [1:0]             i_saveBGBlock,
  input  logic                   i_noblend,
  input  logic [BLOCK_ADR_W-1:0] i_loadAdr,
  input  logic [BLOCK_ADR_W-1:0] i_saveAdr,
  input  logic [BLOCK_W-1:0]     i_exportedBGBlock,
  input  logic [MASK_W-1:0]      i_exportedMSKBGBlock,
  output logic                   o_importBGBlockSingleClock,
  output logic [BLOCK_W-1:0]     o_importedBGBlock,
  output logic                   o_busy,
  output logic                   o_errOverrun,
  bg_block_mem_ctrl_if.master    mem
);

  bg_state_t state;
  bg_req_t   act;
  bg_req_t   req;
  bg_req_t   pend;
  logic      evt;
  logic      pend_vld;
  logic      direct;
  logic      take;
  logic      save_on;
  logic      load_on;

  // DONE with an empty slot consumes a fresh event directly.
  assign direct = (state == IDLE) | ((state == DONE) & ~pend_vld);
  assign take   = (state == DONE) & pend_vld;

  bg_req_slot #(
    .SKIP_EMPTY_SAVE(SKIP_EMPTY_SAVE)
  ) u_slot (
    .clk        (clk),
    .rst_n      (i_nrst),
    .code       (i_saveBGBlock),
    .noblend    (i_noblend),
    .load_adr   (i_loadAdr),
    .save_adr   (i_saveAdr),
    .block      (i_exportedBGBlock),
    .mask       (i_exportedMSKBGBlock),
    .direct     (direct),
    .take       (take),
    .evt        (evt),
    .req        (req),
    .pend_vld   (pend_vld),
    .pend       (pend),
    .err_overrun(o_errOverrun)
  );

  always_ff @(posedge clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state             <= IDLE;
      act               <= '0;
      o_importedBGBlock <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (evt) begin
            act   <= req;
            state <= first_state(req);
          end
        end
        SAVE_CMD: begin
          if (mem.cmd_ready)
            state <= act.do_load ? LOAD_CMD : DONE;
        end
        LOAD_CMD: begin
          if (mem.cmd_ready)
            state <= LOAD_WAIT;
        end
        LOAD_WAIT: begin
          if (mem.rvalid) begin
            o_importedBGBlock <= mem.rdata;
            state             <= IMPORT;
          end
        end
        IMPORT: state <= DONE;
        DONE: begin
          if (take) begin
            act   <= pend;
            state <= first_state(pend);
          end else if (evt) begin
            act   <= req;
            state <= first_state(req);
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign save_on = (state == SAVE_CMD) & act.do_save;
  assign load_on = (state == LOAD_CMD);

  assign mem.cmd_valid = save_on | load_on;
  assign mem.write     = save_on;
  assign mem.adr       = save_on ? act.save_adr :
                         load_on ? act.load_adr : '0;
  assign mem.wdata     = save_on ? act.block : '0;
  assign mem.wmask     = save_on ? act.mask : '0;

  assign o_importBGBlockSingleClock = (state == IMPORT);
  assign o_busy = (state != IDLE) | pend_vld | evt;

endmodule

// File: tb/tb_bg_block_mem_ctrl.sv
// Scoreboard bench for bg_block_mem_ctrl: expected commands/imports
// are queued by stimulus and popped by a negedge monitor.
module tb_bg_block_mem_ctrl;
  import gpu_bg_pkg::*;

  logic         clk = 1'b0;
  logic         nrst;
  logic [1:0]   code;
  logic         noblend;
  logic [14:0]  ladr;
  logic [14:0]  sadr;
  logic [255:0] blk;
  logic [15:0]  msk;
  logic         imp;
  logic [255:0] imp_data;
  logic         busy;
  logic         err;

  bg_block_mem_ctrl_if mem ();

  bg_block_mem_ctrl dut (
    .clk                       (clk),
    .i_nrst                    (nrst),
    .i_saveBGBlock             (code),
    .i_noblend                 (noblend),
    .i_loadAdr                 (ladr),
    .i_saveAdr                 (sadr),
    .i_exportedBGBlock         (blk),
    .i_exportedMSKBGBlock      (msk),
    .o_importBGBlockSingleClock(imp),
    .o_importedBGBlock         (imp_data),
    .o_busy                    (busy),
    .o_errOverrun              (err),
    .mem                       (mem)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         wr;
    logic [14:0]  adr;
    logic [255:0] wdata;
    logic [15:0]  wmask;
  } cmd_t;

  cmd_t         cmd_q[$];
  logic [255:0] imp_q[$];
  int           n_cmp = 0;
  int           n_err = 0;
  bit           resp_en = 1'b1;

  task automatic check(input string nm, input logic [255:0] got,
                       input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, got, exp);
    end
  endtask

  function automatic logic [255:0] rd_of(input logic [14:0] a);
    return (a == 15'h1234) ? {32{8'hA5}} : {16{1'b0, a}};
  endfunction

  function automatic cmd_t mk(input logic wr, input logic [14:0] a,
                              input logic [255:0] d, input logic [15:0] m);
    cmd_t c;
    c.wr = wr; c.adr = a; c.wdata = d; c.wmask = m;
    return c;
  endfunction

  // Monitor
  initial forever begin
    @(negedge clk);
    if (mem.cmd_valid && mem.cmd_ready) begin
      if (cmd_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexp_cmd: got wr=%0b adr=%0h want none",
                 mem.write, mem.adr);
      end else begin
        cmd_t e;
        e = cmd_q.pop_front();
        check("cmd_wr", {255'b0, mem.write}, {255'b0, e.wr});
        check("cmd_adr", {241'b0, mem.adr}, {241'b0, e.adr});
        if (e.wr) begin
          check("cmd_wdata", mem.wdata, e.wdata);
          check("cmd_wmask", {240'b0, mem.wmask}, {240'b0, e.wmask});
        end
      end
    end
    if (imp) begin
      if (imp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexp_import: got data %0h want none", imp_data);
      end else begin
        logic [255:0] d;
        d = imp_q.pop_front();
        check("import_data", imp_data, d);
      end
    end
  end

  // Read responder: data one cycle after an accepted read
  initial forever begin
    @(negedge clk);
    if (resp_en && mem.cmd_valid && mem.cmd_ready && !mem.write) begin
      logic [14:0] a;
      a = mem.adr;
      @(posedge clk);
      #1;
      mem.rvalid = 1'b1;
      mem.rdata  = rd_of(a);
      @(posedge clk);
      #1;
      mem.rvalid = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string nm);
    int k;
    k = 0;
    while (busy && k < 60) begin
      tick();
      k++;
    end
    check(nm, {255'b0, busy}, 256'd0);
  endtask

  task automatic wait_import(input string nm, input int lat);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!imp && n < 12);
    check(nm, n, lat);
  endtask

  initial begin
    nrst = 1'b0; code = 2'b00; noblend = 1'b0;
    ladr = '0; sadr = '0; blk = '0; msk = '0;
    mem.cmd_ready = 1'b1; mem.rvalid = 1'b0; mem.rdata = '0;
    repeat (3) tick();
    check("rst_valid", {255'b0, mem.cmd_valid}, 256'd0);
    check("rst_write", {255'b0, mem.write}, 256'd0);
    check("rst_adr", {241'b0, mem.adr}, 256'd0);
    check("rst_wdata", mem.wdata, 256'd0);
    check("rst_import", {255'b0, imp}, 256'd0);
    check("rst_imp_data", imp_data, 256'd0);
    check("rst_busy", {255'b0, busy}, 256'd0);
    check("rst_err", {255'b0, err}, 256'd0);
    nrst = 1'b1;
    tick();

    // FIRST load with blending
    ladr = 15'h1234;
    cmd_q.push_back(mk(1'b0, 15'h1234, '0, '0));
    imp_q.push_back({32{8'hA5}});
    code = 2'b01;
    #1;
    check("t1_busy_evt", {255'b0, busy}, 256'd1);
    wait_import("t1_latency", 3);
    wait_idle("t1_idle");

    // FIRST with noblend: no traffic
    code = 2'b00;
    tick();
    noblend = 1'b1;
    code = 2'b01;
    #1;
    check("t2_busy_evt", {255'b0, busy}, 256'd1);
    tick();
    check("t2_busy_after", {255'b0, busy}, 256'd0);
    repeat (4) tick();

    // NEXT with backpressure and snapshot
    noblend = 1'b0;
    mem.cmd_ready = 1'b0;
    sadr = 15'h0040; ladr = 15'h0100;
    msk = 16'h00F0; blk = {16{16'h1111}};
    cmd_q.push_back(mk(1'b1, 15'h0040, {16{16'h1111}}, 16'h00F0));
    cmd_q.push_back(mk(1'b0, 15'h0100, '0, '0));
    imp_q.push_back(rd_of(15'h0100));
    code = 2'b10;
    tick();
    blk = {16{16'h2222}};
    for (int i = 0; i < 5; i++) begin
      check("t3_hold_valid", {255'b0, mem.cmd_valid}, 256'd1);
      check("t3_hold_write", {255'b0, mem.write}, 256'd1);
      check("t3_hold_adr", {241'b0, mem.adr}, 256'h40);
      check("t3_hold_wdata", mem.wdata, {16{16'h1111}});
      check("t3_hold_wmask", {240'b0, mem.wmask}, 256'h00F0);
      tick();
    end
    mem.cmd_ready = 1'b1;
    wait_idle("t3_idle");

    // FLUSH with empty mask: skipped
    msk = 16'h0000;
    code = 2'b11;
    #1;
    check("t4_busy_evt", {255'b0, busy}, 256'd1);
    tick();
    check("t4_busy_after", {255'b0, busy}, 256'd0);
    check("t4_valid", {255'b0, mem.cmd_valid}, 256'd0);
    repeat (3) tick();

    // Pending and overrun
    mem.cmd_ready = 1'b0;
    cmd_q.push_back(mk(1'b0, 15'h0A0A, '0, '0));
    imp_q.push_back(rd_of(15'h0A0A));
    cmd_q.push_back(mk(1'b1, 15'h0B0B, {16{16'hBBBB}}, 16'hFFFF));
    cmd_q.push_back(mk(1'b0, 15'h0B0C, '0, '0));
    imp_q.push_back(rd_of(15'h0B0C));
    ladr = 15'h0A0A;
    code = 2'b01;
    tick();
    ladr = 15'h0B0C; sadr = 15'h0B0B;
    blk = {16{16'hBBBB}}; msk = 16'hFFFF;
    code = 2'b10;
    tick();
    check("t5_err_clear", {255'b0, err}, 256'd0);
    sadr = 15'h0C0C; blk = {16{16'hCCCC}};
    code = 2'b11;
    tick();
    check("t5_err_set", {255'b0, err}, 256'd1);
    check("t5_busy", {255'b0, busy}, 256'd1);
    mem.cmd_ready = 1'b1;
    wait_idle("t5_idle");
    check("t5_err_sticky", {255'b0, err}, 256'd1);
    check("t5_cmd_q", cmd_q.size(), 0);
    check("t5_imp_q", imp_q.size(), 0);

    // Async reset in LOAD_WAIT
    code = 2'b00;
    tick();
    resp_en = 1'b0;
    ladr = 15'h0077;
    cmd_q.push_back(mk(1'b0, 15'h0077, '0, '0));
    code = 2'b01;
    tick();
    tick();
    check("t6_busy_wait", {255'b0, busy}, 256'd1);
    code = 2'b00;
    nrst = 1'b0;
    #1;
    check("t6_valid", {255'b0, mem.cmd_valid}, 256'd0);
    check("t6_busy", {255'b0, busy}, 256'd0);
    check("t6_import", {255'b0, imp}, 256'd0);
    check("t6_err", {255'b0, err}, 256'd0);
    check("t6_imp_data", imp_data, 256'd0);
    tick();
    tick();
    nrst = 1'b1;
    mem.rvalid = 1'b1;
    mem.rdata = rd_of(15'h0077);
    tick();
    mem.rvalid = 1'b0;
    repeat (4) tick();
    check("t6_busy_end", {255'b0, busy}, 256'd0);
    check("t6_imp_data_end", imp_data, 256'd0);
    check("end_cmd_q", cmd_q.size(), 0);
    check("end_imp_q", imp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
